// File: rtl/mtl_lcd_pkg.sv
// Timing constants, pixel types and raster-window helpers for the MTL LCD transmitter.
package mtl_lcd_pkg;

  // Raster geometry in panel clocks / lines.
  localparam int unsigned HTotal  = 1056;
  localparam int unsigned VTotal  = 525;
  localparam int unsigned HSync   = 30;
  localparam int unsigned VSync   = 13;
  localparam int unsigned HAct    = 50;
  localparam int unsigned VAct    = 23;
  localparam int unsigned HActive = 800;
  localparam int unsigned VActive = 480;
  localparam int unsigned HImg    = 768;
  localparam int unsigned HBorder = 16;

  // First panel clock of the scaled NES image within a line.
  localparam int unsigned ImgX0 = HAct + HBorder;

  // Counter widths: x spans 0..1055, line spans 0..524.
  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam rgb24_t BorderRgb = 24'h101010;
  localparam rgb24_t BlackRgb  = 24'h000000;

  // Per-clock timing flags carried down the latency-matching delay line.
  typedef struct packed {
    logic hsd;
    logic vsd;
    logic de;
    logic img;
    logic fs;
  } tflag_t;

  // Idle raster: syncs deasserted (high), no data, no frame marker.
  localparam tflag_t FlagRst = '{hsd: 1'b1, vsd: 1'b1, de: 1'b0, img: 1'b0, fs: 1'b0};

  // True inside the 800x480 active window.
  function automatic logic in_de(logic [XW-1:0] x, logic [YW-1:0] y);
    return (x >= XW'(HAct)) && (x < XW'(HAct + HActive)) &&
           (y >= YW'(VAct)) && (y < YW'(VAct + VActive));
  endfunction

  // True inside the 768-wide scaled image, i.e. active window minus side borders.
  function automatic logic in_img(logic [XW-1:0] x, logic [YW-1:0] y);
    return in_de(x, y) && (x >= XW'(ImgX0)) && (x < XW'(ImgX0 + HImg));
  endfunction

endpackage

// File: rtl/mtl_pipe_dly.sv
// Fixed-depth shift register with a per-bit synchronous reset value.
module mtl_pipe_dly #(
  parameter int unsigned       Width  = 1,
  parameter int unsigned       Depth  = 1,
  parameter logic [Width-1:0]  RstVal = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] stage_q [Depth];

  // Shift one stage per clock; reset flushes every stage to the idle value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= RstVal;
      end
    end else begin
      stage_q[0] <= i_d;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign o_q = stage_q[Depth-1];

endmodule

// File: rtl/mtl_lcd_tx.sv
// MTL panel transmitter: raster timing, x3/x2 NES scaling, pixel fetch and
// latency-matched RGB output.
module mtl_lcd_tx
  import mtl_lcd_pkg::*;
#(
  // Clocks from o_pix_req to valid i_pix_rgb; legal range 1..4.
  parameter int unsigned RD_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_hsd,
  output logic        o_vsd,
  output logic        o_de,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_pix_req,
  output logic [7:0]  o_pix_x,
  output logic [7:0]  o_pix_y,
  input  logic [23:0] i_pix_rgb,
  output logic        o_frame_start
);

  // Stage-0 raster position.
  logic [XW-1:0] xcnt_q, xcnt_d;
  logic [YW-1:0] line_q, line_d;
  logic          x_wrap;

  // Fetch side, aligned with stage 0.
  logic [1:0]    sub_q, sub_d;
  logic [7:0]    pix_x_q, pix_x_d;
  logic [7:0]    pix_y_q, pix_y_d;
  logic          req_q, req_d;

  // Timing flags at stage 0 and after the read-latency delay.
  tflag_t        flags0;
  tflag_t        flags_dly;

  // Output register.
  logic          hsd_q, vsd_q, de_q, fs_q;
  rgb24_t        rgb_q, rgb_d;

  // Next raster position; x and line wrap on the same edge at end of frame.
  always_comb begin
    x_wrap = (xcnt_q == XW'(HTotal - 1));
    xcnt_d = x_wrap ? '0 : xcnt_q + XW'(1);
    line_d = line_q;
    if (x_wrap) begin
      line_d = (line_q == YW'(VTotal - 1)) ? '0 : line_q + YW'(1);
    end
  end

  // Stage-0 timing flags decoded from the current raster position.
  always_comb begin
    flags0.hsd = (xcnt_q >= XW'(HSync));
    flags0.vsd = (line_q >= YW'(VSync));
    flags0.de  = in_de(xcnt_q, line_q);
    flags0.img = in_img(xcnt_q, line_q);
    flags0.fs  = (xcnt_q == '0) && (line_q == '0);
  end

  // Fetch request and NES coordinates, computed one clock early from the next
  // raster position so the registered request lines up with stage 0.
  always_comb begin
    req_d   = in_img(xcnt_d, line_d);
    sub_d   = sub_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    if (req_d) begin
      if (xcnt_d == XW'(ImgX0)) begin
        sub_d   = 2'd0;
        pix_x_d = 8'd0;
      end else if (sub_q == 2'd2) begin
        sub_d   = 2'd0;
        pix_x_d = pix_x_q + 8'd1;
      end else begin
        sub_d   = sub_q + 2'd1;
      end
      // Each NES row is shown on two consecutive panel lines.
      pix_y_d = 8'((line_d - YW'(VAct)) >> 1);
    end
  end

  // Raster counters and fetch-side state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      xcnt_q  <= '0;
      line_q  <= '0;
      sub_q   <= 2'd0;
      pix_x_q <= 8'd0;
      pix_y_q <= 8'd0;
      req_q   <= 1'b0;
    end else begin
      xcnt_q  <= xcnt_d;
      line_q  <= line_d;
      sub_q   <= sub_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      req_q   <= req_d;
    end
  end

  // Hold the timing flags for RD_LAT clocks so they meet the returning pixel.
  mtl_pipe_dly #(
    .Width  ($bits(tflag_t)),
    .Depth  (RD_LAT),
    .RstVal (FlagRst)
  ) u_flag_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (flags0),
    .o_q   (flags_dly)
  );

  // Colour select: fetched pixel inside the image, border colour in the rest
  // of the active window, black elsewhere.
  always_comb begin
    rgb_d = BlackRgb;
    if (flags_dly.img) begin
      rgb_d = rgb24_t'(i_pix_rgb);
    end else if (flags_dly.de) begin
      rgb_d = BorderRgb;
    end
  end

  // Output register: every output is stage 0 delayed by RD_LAT+1 clocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hsd_q <= 1'b1;
      vsd_q <= 1'b1;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      rgb_q <= BlackRgb;
    end else begin
      hsd_q <= flags_dly.hsd;
      vsd_q <= flags_dly.vsd;
      de_q  <= flags_dly.de;
      fs_q  <= flags_dly.fs;
      rgb_q <= rgb_d;
    end
  end

  assign o_hsd         = hsd_q;
  assign o_vsd         = vsd_q;
  assign o_de          = de_q;
  assign o_r           = rgb_q.r;
  assign o_g           = rgb_q.g;
  assign o_b           = rgb_q.b;
  assign o_frame_start = fs_q;
  assign o_pix_req     = req_q;
  assign o_pix_x       = pix_x_q;
  assign o_pix_y       = pix_y_q;

endmodule
